// File: rtl/cva6_pma_pkg.sv
// rtl/cva6_pma_pkg.sv - shared PMA attribute/entry types for the region table
package cva6_pma_pkg;

    localparam int unsigned AddrWidth = 64;

    localparam int unsigned AttrExecBit    = 2;
    localparam int unsigned AttrCachedBit  = 1;
    localparam int unsigned AttrNonidemBit = 0;

    typedef struct packed {
        logic exec;
        logic cached;
        logic nonidem;
    } pma_attr_t;

    typedef struct packed {
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] length;
        pma_attr_t            attr;
        logic                 lock;
    } pma_entry_t;

endpackage

// File: rtl/cva6_pma_match.sv
// rtl/cva6_pma_match.sv - combinational match of one address against all PMA entries
module cva6_pma_match
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0]                 addr_i,
    input  logic [NrRegions-1:0][AddrWidth-1:0]  base_i,
    input  logic [NrRegions-1:0][AddrWidth-1:0]  length_i,
    input  pma_attr_t [NrRegions-1:0]            attr_i,
    output pma_attr_t                            attr_o,
    output logic                                 hit_o
);

    logic [NrRegions-1:0] match;

    // End address carries one extra bit so a region reaching the top of memory does not wrap.
    for (genvar i = 0; i < NrRegions; i++) begin : g_entry
        logic [AddrWidth:0] end_addr;
        assign end_addr = {1'b0, base_i[i]} + {1'b0, length_i[i]};
        assign match[i] = (length_i[i] != '0) && (addr_i >= base_i[i]) &&
                          ({1'b0, addr_i} < end_addr);
    end

    always_comb begin
        attr_o = '0;
        for (int i = 0; i < NrRegions; i++) begin
            if (match[i]) begin
                attr_o = attr_o | attr_i[i];
            end
        end
    end

    assign hit_o = |match;

endmodule

// File: rtl/cva6_pma_region_table.sv
// rtl/cva6_pma_region_table.sv - run-time writable PMA region table; lock bits under CVA6_PMA_REGION_LOCK_EN
module cva6_pma_region_table
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRegions     = 8,
    parameter int unsigned NrLookupPorts = 2,
    parameter int unsigned AddrWidth     = 64,
    parameter logic [NrRegions*64-1:0] RstBase   = {NrRegions{64'h0}},
    parameter logic [NrRegions*64-1:0] RstLength = {NrRegions{64'h0}},
    parameter logic [NrRegions*3-1:0]  RstAttr   = '0,
    localparam int unsigned IdxWidth = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     cfg_valid_i,
    input  logic [IdxWidth-1:0]                      cfg_idx_i,
    input  pma_entry_t                               cfg_entry_i,
    output logic                                     cfg_done_o,
    output logic                                     cfg_err_o,
    input  logic [NrLookupPorts-1:0]                 lk_valid_i,
    input  logic [NrLookupPorts-1:0][AddrWidth-1:0]  lk_addr_i,
    output logic [NrLookupPorts-1:0]                 lk_valid_o,
    output pma_attr_t [NrLookupPorts-1:0]            lk_attr_o,
    output logic [NrLookupPorts-1:0]                 lk_hit_o
);

    logic [NrRegions-1:0][AddrWidth-1:0] base_q;
    logic [NrRegions-1:0][AddrWidth-1:0] length_q;
    pma_attr_t [NrRegions-1:0]           attr_q;

    logic [NrRegions-1:0] wr_sel;
    logic                 idx_ok;
    logic                 locked;
    logic                 wr_err;
    logic                 wr_en;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NrRegions; i++) begin
            wr_sel[i] = (cfg_idx_i == IdxWidth'(i));
        end
    end

    assign idx_ok = ({1'b0, cfg_idx_i} < (IdxWidth+1)'(NrRegions));

`ifdef CVA6_PMA_REGION_LOCK_EN
    logic [NrRegions-1:0] lock_q;

    assign locked = |(lock_q & wr_sel);

    // Locks are sticky: only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= '0;
        end else if (wr_en) begin
            lock_q <= lock_q | (wr_sel & {NrRegions{cfg_entry_i.lock}});
        end
    end
`else
    assign locked = 1'b0;
`endif

    assign wr_err = !idx_ok || locked;
    assign wr_en  = cfg_valid_i && !wr_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRegions; i++) begin
                base_q[i]   <= RstBase[64*i +: AddrWidth];
                length_q[i] <= RstLength[64*i +: AddrWidth];
                attr_q[i]   <= RstAttr[3*i +: 3];
            end
        end else if (wr_en) begin
            for (int i = 0; i < NrRegions; i++) begin
                if (wr_sel[i]) begin
                    base_q[i]   <= cfg_entry_i.base[AddrWidth-1:0];
                    length_q[i] <= cfg_entry_i.length[AddrWidth-1:0];
                    attr_q[i]   <= cfg_entry_i.attr;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_done_o <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            cfg_done_o <= cfg_valid_i;
            cfg_err_o  <= cfg_valid_i && wr_err;
        end
    end

    pma_attr_t [NrLookupPorts-1:0] match_attr;
    logic [NrLookupPorts-1:0]      match_hit;

    // Matching happens in the issue cycle against the pre-write table; only the result is registered.
    for (genvar p = 0; p < NrLookupPorts; p++) begin : g_port
        cva6_pma_match #(
            .NrRegions (NrRegions),
            .AddrWidth (AddrWidth)
        ) u_match (
            .addr_i   (lk_addr_i[p]),
            .base_i   (base_q),
            .length_i (length_q),
            .attr_i   (attr_q),
            .attr_o   (match_attr[p]),
            .hit_o    (match_hit[p])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_valid_o <= '0;
            lk_attr_o  <= '0;
            lk_hit_o   <= '0;
        end else begin
            lk_valid_o <= lk_valid_i;
            for (int p = 0; p < NrLookupPorts; p++) begin
                lk_attr_o[p] <= lk_valid_i[p] ? match_attr[p] : '0;
                lk_hit_o[p]  <= lk_valid_i[p] && match_hit[p];
            end
        end
    end

endmodule

// File: tb/tb_cva6_pma_region_table.sv
// tb/tb_cva6_pma_region_table.sv - scoreboard bench for cva6_pma_region_table
module tb_cva6_pma_region_table;
    import cva6_pma_pkg::*;

    localparam int unsigned NR = 6;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 64;
    localparam logic [NR*64-1:0] RST_BASE = 384'h8000_0000;
    localparam logic [NR*64-1:0] RST_LEN  = 384'h4000_0000;
    localparam logic [NR*3-1:0]  RST_ATTR = 18'b110;

    localparam logic [2:0] X  = 3'(1 << AttrExecBit);
    localparam logic [2:0] C  = 3'(1 << AttrCachedBit);
    localparam logic [2:0] NI = 3'(1 << AttrNonidemBit);

`ifdef CVA6_PMA_REGION_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst_i = 1'b1;
    logic                         cfg_valid_i = 1'b0;
    logic [2:0]                   cfg_idx_i = '0;
    pma_entry_t                   cfg_entry_i = '0;
    logic                         cfg_done_o;
    logic                         cfg_err_o;
    logic [NP-1:0]                lk_valid_i = '0;
    logic [NP-1:0][AW-1:0]        lk_addr_i = '0;
    logic [NP-1:0]                lk_valid_o;
    pma_attr_t [NP-1:0]           lk_attr_o;
    logic [NP-1:0]                lk_hit_o;

    cva6_pma_region_table #(
        .NrRegions     (NR),
        .NrLookupPorts (NP),
        .AddrWidth     (AW),
        .RstBase       (RST_BASE),
        .RstLength     (RST_LEN),
        .RstAttr       (RST_ATTR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_entry_i (cfg_entry_i),
        .cfg_done_o  (cfg_done_o),
        .cfg_err_o   (cfg_err_o),
        .lk_valid_i  (lk_valid_i),
        .lk_addr_i   (lk_addr_i),
        .lk_valid_o  (lk_valid_o),
        .lk_attr_o   (lk_attr_o),
        .lk_hit_o    (lk_hit_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [3:0] exp_lk [NP][$];
    logic       exp_cfg [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: pops one expectation per presented result.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (lk_valid_o[p]) begin
                if (exp_lk[p].size() == 0) begin
                    total++;
                    $display("FAIL lk%0d_unexpected: got hit=%0b attr=%03b, required no result",
                             p, lk_hit_o[p], lk_attr_o[p]);
                end else begin
                    check($sformatf("lk%0d_result", p), 64'({lk_hit_o[p], lk_attr_o[p]}),
                          64'(exp_lk[p].pop_front()));
                end
            end
        end
        if (cfg_done_o) begin
            if (exp_cfg.size() == 0) begin
                total++;
                $display("FAIL cfg_unexpected: got done with err=%0b, required no done", cfg_err_o);
            end else begin
                check("cfg_err", 64'(cfg_err_o), 64'(exp_cfg.pop_front()));
            end
        end
    end

    task automatic lookup(input int p, input logic [63:0] a, input logic hit, input logic [2:0] attr);
        lk_valid_i[p] = 1'b1;
        lk_addr_i[p]  = a;
        exp_lk[p].push_back({hit, attr});
    endtask

    task automatic write(input int idx, input logic [63:0] b, input logic [63:0] len,
                         input logic [2:0] attr, input logic lock, input logic err);
        cfg_valid_i        = 1'b1;
        cfg_idx_i          = 3'(idx);
        cfg_entry_i.base   = b;
        cfg_entry_i.length = len;
        cfg_entry_i.attr   = attr;
        cfg_entry_i.lock   = lock;
        exp_cfg.push_back(err);
    endtask

    task automatic next();
        @(negedge clk);
        lk_valid_i  = '0;
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({lk_valid_o, lk_hit_o, lk_attr_o, cfg_done_o, cfg_err_o}), 64'h0);
        rst_i = 1'b0;

        // Reset defaults
        lookup(0, 64'h8000_1000, 1'b1, X | C);
        lookup(1, 64'h7FFF_FFFF, 1'b0, 3'b000);
        next();
        lookup(0, 64'hBFFF_FFFF, 1'b1, X | C);
        lookup(1, 64'hC000_0000, 1'b0, 3'b000);
        next();

        // Range boundaries and zero length
        write(1, 64'h1_0000, 64'h1_0000, NI, 1'b0, 1'b0);
        next();
        lookup(0, 64'h1_FFFF, 1'b1, NI);
        lookup(1, 64'h2_0000, 1'b0, 3'b000);
        next();
        lookup(0, 64'h1_0000, 1'b1, NI);
        write(2, 64'h5000, 64'h0, X, 1'b0, 1'b0);
        next();
        lookup(0, 64'h5000, 1'b0, 3'b000);
        next();

        // Region ending at the top of the address space
        write(2, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, X, 1'b0, 1'b0);
        next();
        lookup(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, X);
        lookup(1, 64'h0, 1'b0, 3'b000);
        next();
        lookup(0, 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'b000);
        next();

        // Same-cycle write/lookup, then overlap accumulation
        write(3, 64'h2000, 64'h1000, C, 1'b0, 1'b0);
        lookup(0, 64'h2000, 1'b0, 3'b000);
        next();
        lookup(0, 64'h2000, 1'b1, C);
        write(5, 64'h2800, 64'h1000, NI, 1'b0, 1'b0);
        next();
        lookup(0, 64'h2800, 1'b1, C | NI);
        lookup(1, 64'h3000, 1'b1, NI);
        next();

        // Lock and out-of-range index
        write(4, 64'h4000, 64'h100, X, 1'b1, 1'b0);
        next();
        write(4, 64'h4000, 64'h100, NI, 1'b0, LockEn);
        next();
        lookup(0, 64'h4000, 1'b1, LockEn ? X : NI);
        write(6, 64'h6000, 64'h100, X, 1'b0, 1'b1);
        next();
        write(7, 64'h6000, 64'h100, X, 1'b0, 1'b1);
        lookup(1, 64'h6000, 1'b0, 3'b000);
        next();
        next();

        // Reset while a lookup and a write are in flight
        lk_valid_i   = '1;
        lk_addr_i[0] = 64'h8000_1000;
        lk_addr_i[1] = 64'h2000;
        cfg_valid_i  = 1'b1;
        cfg_idx_i    = 3'd1;
        cfg_entry_i  = '0;
        #2 rst_i = 1'b1;
        next();
        check("midreset_outputs", 64'({lk_valid_o, lk_hit_o, lk_attr_o, cfg_done_o, cfg_err_o}), 64'h0);
        rst_i = 1'b0;
        next();
        check("postreset_idle", 64'({lk_valid_o, cfg_done_o}), 64'h0);

        lookup(0, 64'h8000_1000, 1'b1, X | C);
        lookup(1, 64'h1_0000, 1'b0, 3'b000);
        next();
        lookup(0, 64'h2000, 1'b0, 3'b000);
        lookup(1, 64'h4000, 1'b0, 3'b000);
        write(4, 64'h4000, 64'h100, C, 1'b0, 1'b0);
        next();
        lookup(0, 64'h4000, 1'b1, C);
        next();
        next();
        next();

        check("lk0_drained", 64'(exp_lk[0].size()), 64'h0);
        check("lk1_drained", 64'(exp_lk[1].size()), 64'h0);
        check("cfg_drained", 64'(exp_cfg.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
